hazard_sequencer: RTL and testbench

Pipeline hazard controller for the 5-stage core. It owns all stall, bubble, flush and replay decisions: load-use interlock, taken-branch/jump redirect, and multi-cycle data-memory waits. It drives the hold and flush enables of the PC, IF/ID, ID/EX and EX/MEM registers, and the replay mux into IF/ID. It also keeps saturating stall and flush performance counters.

---
 rtl/core_pkg.sv | 18 +
 rtl/hazard_detect.sv | 20 ++
 rtl/hazard_sequencer.sv | 150 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: default widths, the canonical NOP encoding and the
// hazard sequencer state type.
package core_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int RA_W_DEF   = 5;
   localparam int PERF_W_DEF = 32;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN,
      LU_STALL,
      MEM_WAIT
   } hz_state_t;

endpackage : core_pkg

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an IF/ID source register that matches a load
// destination still sitting in ID/EX. Also used by the forwarding logic.
module hazard_detect #(
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] rs1_addr,
   input  logic [RA_W-1:0] rs2_addr,
   input  logic            rs1_used,
   input  logic            rs2_used,
   input  logic            de_load,
   input  logic [RA_W-1:0] de_rd,
   output logic            lu_hit
);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign lu_hit = de_load && (de_rd != '0) &&
                   ((rs1_used && (rs1_addr == de_rd)) ||
                    (rs2_used && (rs2_addr == de_rd)));

endmodule : hazard_detect

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use interlock with replay, EX redirect
// flushes and data-memory wait holds, plus saturating stall/flush counters.
module hazard_sequencer
   import core_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int RA_W   = RA_W_DEF,
   parameter int PERF_W = PERF_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   fd_inst,
   input  logic [XLEN-1:0]   fd_pc,
   input  logic [RA_W-1:0]   rs1_addr,
   input  logic [RA_W-1:0]   rs2_addr,
   input  logic              rs1_used,
   input  logic              rs2_used,
   input  logic              de_load,
   input  logic [RA_W-1:0]   de_rd,
   input  logic              ex_redirect,
   input  logic [XLEN-1:0]   ex_target,
   input  logic              dmem_req,
   input  logic              dmem_ready,
   output logic              pc_hold,
   output logic              fd_hold,
   output logic              de_hold,
   output logic              em_hold,
   output logic              de_bubble,
   output logic              fd_flush,
   output logic              de_flush,
   output logic              wb_bubble,
   output logic              pc_redirect,
   output logic [XLEN-1:0]   pc_target,
   output logic              replay_sel,
   output logic [XLEN-1:0]   replay_inst,
   output logic [XLEN-1:0]   replay_pc,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] flush_count
);

   hz_state_t state;
   hz_state_t resume;
   logic      lu_hit;
   logic      mem_wait;
   logic      any_hold;

   hazard_detect #(.RA_W(RA_W)) u_detect (
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used),
      .de_load  (de_load),
      .de_rd    (de_rd),
      .lu_hit   (lu_hit)
   );

   assign mem_wait = dmem_req & ~dmem_ready;

   // Control outputs respond in the same cycle; a memory wait overrides
   // everything, then a redirect, then the load-use interlock.
   always_comb begin
      // NOTE: every output is defaulted first so no branch can leave one unassigned (no latch).
      pc_hold     = 1'b0;
      fd_hold     = 1'b0;
      de_hold     = 1'b0;
      em_hold     = 1'b0;
      de_bubble   = 1'b0;
      fd_flush    = 1'b0;
      de_flush    = 1'b0;
      wb_bubble   = 1'b0;
      pc_redirect = 1'b0;
      replay_sel  = 1'b0;
      pc_target   = '0;
      if (rst_n) begin
         pc_target = ex_target;
         case (state)
            RUN, LU_STALL: begin
               if (mem_wait) begin
                  pc_hold   = 1'b1;
                  fd_hold   = 1'b1;
                  de_hold   = 1'b1;
                  em_hold   = 1'b1;
                  wb_bubble = 1'b1;
               end else if (ex_redirect) begin
                  pc_redirect = 1'b1;
                  fd_flush    = 1'b1;
                  de_flush    = 1'b1;
               end else if (lu_hit) begin
                  pc_hold   = 1'b1;
                  fd_hold   = 1'b1;
                  de_bubble = 1'b1;
               end else begin
                  replay_sel = (state == LU_STALL);
               end
            end
            MEM_WAIT: begin
               if (!dmem_ready) begin
                  pc_hold   = 1'b1;
                  fd_hold   = 1'b1;
                  de_hold   = 1'b1;
                  em_hold   = 1'b1;
                  wb_bubble = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign any_hold = pc_hold | fd_hold | de_hold | em_hold;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         state        <= RUN;
         resume       <= RUN;
         replay_inst  <= XLEN'(NOP_INST);
         replay_pc    <= '0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         case (state)
            RUN, LU_STALL: begin
               if (mem_wait) begin
                  resume <= state;
                  state  <= MEM_WAIT;
               end else if (ex_redirect) begin
                  state <= RUN;
               end else if (lu_hit) begin
                  replay_inst <= fd_inst;
                  replay_pc   <= fd_pc;
                  state       <= LU_STALL;
               end else begin
                  state <= RUN;
               end
            end
            MEM_WAIT: begin
               if (dmem_ready) state <= resume;
            end
            default: state <= RUN;
         endcase

         if (any_hold && (stall_cycles != '1))
            stall_cycles <= stall_cycles + PERF_W'(1);
         if (pc_redirect && (flush_count != '1))
            flush_count <= flush_count + PERF_W'(1);
      end
   end

endmodule : hazard_sequencer

// File: tb/tb_hazard_sequencer.sv
// Scenario bench for hazard_sequencer: expected control vectors are queued as
// stimulus is driven and compared by a negedge monitor; registers checked inline.
module tb_hazard_sequencer;
   import core_pkg::*;

   localparam int XLEN   = 32;
   localparam int RA_W   = 5;
   localparam int PERF_W = 8;

   // {pc_hold, fd_hold, de_hold, em_hold, de_bubble, fd_flush, de_flush, wb_bubble, pc_redirect, replay_sel}
   localparam logic [9:0] O_NONE   = 10'b00000_00000;
   localparam logic [9:0] O_LU     = 10'b11001_00000;
   localparam logic [9:0] O_REDIR  = 10'b00000_11010;
   localparam logic [9:0] O_MEM    = 10'b11110_00100;
   localparam logic [9:0] O_REPLAY = 10'b00000_00001;

   logic              clk;
   logic              rst_n;
   logic [XLEN-1:0]   fd_inst, fd_pc, ex_target;
   logic [RA_W-1:0]   rs1_addr, rs2_addr, de_rd;
   logic              rs1_used, rs2_used, de_load, ex_redirect, dmem_req, dmem_ready;
   logic              pc_hold, fd_hold, de_hold, em_hold, de_bubble;
   logic              fd_flush, de_flush, wb_bubble, pc_redirect, replay_sel;
   logic [XLEN-1:0]   pc_target, replay_inst, replay_pc;
   logic [PERF_W-1:0] stall_cycles, flush_count;

   hazard_sequencer #(.XLEN(XLEN), .RA_W(RA_W), .PERF_W(PERF_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fd_inst      (fd_inst),
      .fd_pc        (fd_pc),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_used     (rs1_used),
      .rs2_used     (rs2_used),
      .de_load      (de_load),
      .de_rd        (de_rd),
      .ex_redirect  (ex_redirect),
      .ex_target    (ex_target),
      .dmem_req     (dmem_req),
      .dmem_ready   (dmem_ready),
      .pc_hold      (pc_hold),
      .fd_hold      (fd_hold),
      .de_hold      (de_hold),
      .em_hold      (em_hold),
      .de_bubble    (de_bubble),
      .fd_flush     (fd_flush),
      .de_flush     (de_flush),
      .wb_bubble    (wb_bubble),
      .pc_redirect  (pc_redirect),
      .pc_target    (pc_target),
      .replay_sel   (replay_sel),
      .replay_inst  (replay_inst),
      .replay_pc    (replay_pc),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [9:0] outs;
   } exp_t;

   exp_t              exp_q[$];
   exp_t              mon_e;
   int                checks = 0;
   int                errors = 0;
   logic [PERF_W-1:0] exp_stall = '0;
   logic [PERF_W-1:0] exp_flush = '0;

   function automatic logic [9:0] outs();
      return {pc_hold, fd_hold, de_hold, em_hold, de_bubble,
              fd_flush, de_flush, wb_bubble, pc_redirect, replay_sel};
   endfunction

   // Scoreboard consumer: compares the control vector queued for this cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (outs() !== mon_e.outs) begin
            errors++;
            $display("FAIL %s outs=%b expected=%b", mon_e.name, outs(), mon_e.outs);
         end
      end
   end

   task automatic idle();
      rst_n = 1'b1; fd_inst = '0; fd_pc = '0; rs1_addr = '0; rs2_addr = '0;
      rs1_used = 1'b0; rs2_used = 1'b0; de_load = 1'b0; de_rd = '0;
      ex_redirect = 1'b0; ex_target = '0; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lu(input logic [XLEN-1:0] inst, input logic [XLEN-1:0] pc);
      de_load = 1'b1; de_rd = 5'd5; rs1_addr = 5'd5; rs1_used = 1'b1;
      fd_inst = inst; fd_pc = pc;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      set_lu(32'h0052_8333, 32'h100);
      ex_redirect = 1'b1; ex_target = 32'h55; dmem_req = 1'b1;
      exp_q.push_back('{"rst_outs_forced_low", O_NONE});
      @(negedge clk);
      checks++;
      if (pc_target !== '0) begin
         errors++; $display("FAIL rst_pc_target got %h want 0", pc_target);
      end
      next_cycle();
      checks++;
      if (replay_inst !== 32'h0000_0013 || replay_pc !== '0) begin
         errors++; $display("FAIL rst_replay got %h/%h want 00000013/0", replay_inst, replay_pc);
      end
      checks++;
      if (stall_cycles !== '0 || flush_count !== '0) begin
         errors++; $display("FAIL rst_counters got %0d/%0d want 0/0", stall_cycles, flush_count);
      end
      exp_q.push_back('{"rst_held", O_NONE});
      next_cycle();
      idle();
      exp_q.push_back('{"rst_run_idle", O_NONE});
   endtask

   task automatic test_load_use();
      next_cycle(); idle(); set_lu(32'h0052_8333, 32'h100);
      exp_q.push_back('{"lu_stall", O_LU});
      next_cycle(); idle(); exp_stall++;
      exp_q.push_back('{"lu_replay", O_REPLAY});
      checks++;
      if (replay_inst !== 32'h0052_8333 || replay_pc !== 32'h100) begin
         errors++; $display("FAIL lu_capture got %h/%h want 00528333/100", replay_inst, replay_pc);
      end
      checks++;
      if (stall_cycles !== exp_stall) begin
         errors++; $display("FAIL lu_stall_cycles got %0d want %0d", stall_cycles, exp_stall);
      end
      next_cycle(); idle();
      exp_q.push_back('{"lu_back_to_run", O_NONE});
   endtask

   task automatic test_no_hazard();
      next_cycle(); idle();
      de_load = 1'b1; de_rd = '0; rs1_addr = '0; rs1_used = 1'b1; fd_inst = 32'hBAD0_0001;
      exp_q.push_back('{"nh_x0", O_NONE});
      next_cycle(); idle();
      de_load = 1'b1; de_rd = 5'd7; rs2_addr = 5'd7; rs2_used = 1'b0;
      rs1_addr = 5'd3; rs1_used = 1'b1; fd_inst = 32'hBAD0_0002;
      exp_q.push_back('{"nh_rs2_unused", O_NONE});
      next_cycle(); idle();
      de_load = 1'b0; de_rd = 5'd7; rs1_addr = 5'd7; rs1_used = 1'b1; fd_inst = 32'hBAD0_0003;
      exp_q.push_back('{"nh_not_load", O_NONE});
      next_cycle(); idle();
      checks++;
      if (replay_inst !== 32'h0052_8333) begin
         errors++; $display("FAIL nh_replay_kept got %h want 00528333", replay_inst);
      end
      de_load = 1'b1; de_rd = 5'd7; rs2_addr = 5'd7; rs2_used = 1'b1;
      fd_inst = 32'h0073_9463; fd_pc = 32'h180;
      exp_q.push_back('{"lu_rs2", O_LU});
      next_cycle(); idle(); exp_stall++;
      exp_q.push_back('{"lu_rs2_replay", O_REPLAY});
      checks++;
      if (replay_inst !== 32'h0073_9463 || replay_pc !== 32'h180) begin
         errors++; $display("FAIL lu_rs2_capture got %h/%h want 00739463/180", replay_inst, replay_pc);
      end
   endtask

   task automatic test_redirect();
      next_cycle(); idle();
      ex_redirect = 1'b1; ex_target = 32'h200; set_lu(32'h1111_1111, 32'h300);
      exp_q.push_back('{"redir_over_lu", O_REDIR});
      @(negedge clk);
      checks++;
      if (pc_target !== 32'h200) begin
         errors++; $display("FAIL redir_target got %h want 200", pc_target);
      end
      next_cycle(); idle(); exp_flush++;
      exp_q.push_back('{"redir_no_lu_stall", O_NONE});
      checks++;
      if (flush_count !== exp_flush) begin
         errors++; $display("FAIL redir_flush_count got %0d want %0d", flush_count, exp_flush);
      end
      checks++;
      if (replay_inst !== 32'h0073_9463 || replay_pc !== 32'h180) begin
         errors++; $display("FAIL redir_no_capture got %h/%h want 00739463/180", replay_inst, replay_pc);
      end
      next_cycle(); idle(); set_lu(32'h0044_4444, 32'h400);
      exp_q.push_back('{"redir_pre_lu", O_LU});
      next_cycle(); idle(); exp_stall++;
      ex_redirect = 1'b1; ex_target = 32'h240;
      exp_q.push_back('{"redir_in_lu_stall", O_REDIR});
      next_cycle(); exp_flush++;
      exp_q.push_back('{"redir_b2b", O_REDIR});
      next_cycle(); idle(); exp_flush++;
      exp_q.push_back('{"redir_done", O_NONE});
      checks++;
      if (flush_count !== exp_flush) begin
         errors++; $display("FAIL redir_b2b_count got %0d want %0d", flush_count, exp_flush);
      end
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 3; i++) begin
         next_cycle(); idle(); dmem_req = 1'b1;
         exp_q.push_back('{$sformatf("mem_hold_%0d", i), O_MEM});
      end
      exp_stall += 3;
      next_cycle(); idle(); dmem_req = 1'b1; dmem_ready = 1'b1;
      exp_q.push_back('{"mem_release", O_NONE});
      next_cycle(); idle();
      exp_q.push_back('{"mem_after", O_NONE});
      checks++;
      if (stall_cycles !== exp_stall) begin
         errors++; $display("FAIL mem_stall_cycles got %0d want %0d", stall_cycles, exp_stall);
      end
      // Wait entered from LU_STALL must come back and finish the replay.
      next_cycle(); idle(); set_lu(32'h00A3_8433, 32'h500);
      exp_q.push_back('{"mlu_stall", O_LU});
      next_cycle(); idle(); dmem_req = 1'b1;
      exp_q.push_back('{"mlu_hold_0", O_MEM});
      next_cycle(); idle(); dmem_req = 1'b1;
      exp_q.push_back('{"mlu_hold_1", O_MEM});
      next_cycle(); idle(); dmem_req = 1'b1; dmem_ready = 1'b1;
      exp_q.push_back('{"mlu_release", O_NONE});
      next_cycle(); idle();
      exp_q.push_back('{"mlu_replay", O_REPLAY});
      checks++;
      if (replay_pc !== 32'h500) begin
         errors++; $display("FAIL mlu_replay_pc got %h want 500", replay_pc);
      end
      next_cycle(); idle();
      exp_q.push_back('{"mlu_run", O_NONE});
      exp_stall += 3;
      // Redirect arriving during a wait is only acted on after release.
      next_cycle(); idle(); dmem_req = 1'b1; ex_redirect = 1'b1; ex_target = 32'h600;
      exp_q.push_back('{"mred_hold_0", O_MEM});
      next_cycle();
      exp_q.push_back('{"mred_hold_1", O_MEM});
      next_cycle(); dmem_ready = 1'b1;
      exp_q.push_back('{"mred_release", O_NONE});
      next_cycle(); dmem_req = 1'b0; dmem_ready = 1'b0;
      exp_q.push_back('{"mred_redirect", O_REDIR});
      next_cycle(); idle(); exp_stall += 2; exp_flush++;
      exp_q.push_back('{"mred_done", O_NONE});
      checks++;
      if (stall_cycles !== exp_stall || flush_count !== exp_flush) begin
         errors++; $display("FAIL mred_counters got %0d/%0d want %0d/%0d",
                            stall_cycles, flush_count, exp_stall, exp_flush);
      end
   endtask

   task automatic test_reset_mid();
      next_cycle(); idle(); dmem_req = 1'b1;
      exp_q.push_back('{"rmid_mem_enter", O_MEM});
      next_cycle(); idle(); rst_n = 1'b0; dmem_req = 1'b1;
      exp_q.push_back('{"rmid_mem_forced", O_NONE});
      next_cycle(); idle();
      exp_q.push_back('{"rmid_mem_abandoned", O_NONE});
      exp_stall = '0; exp_flush = '0;
      checks++;
      if (stall_cycles !== '0 || flush_count !== '0 || replay_inst !== 32'h0000_0013 || replay_pc !== '0) begin
         errors++; $display("FAIL rmid_mem_regs got %0d/%0d/%h/%h want 0/0/00000013/0",
                            stall_cycles, flush_count, replay_inst, replay_pc);
      end
      next_cycle(); idle(); set_lu(32'h0066_6666, 32'h700);
      exp_q.push_back('{"rmid_lu_enter", O_LU});
      next_cycle(); idle(); rst_n = 1'b0;
      exp_q.push_back('{"rmid_lu_forced", O_NONE});
      next_cycle(); idle();
      exp_q.push_back('{"rmid_lu_abandoned", O_NONE});
      checks++;
      if (stall_cycles !== '0 || replay_inst !== 32'h0000_0013) begin
         errors++; $display("FAIL rmid_lu_regs got %0d/%h want 0/00000013", stall_cycles, replay_inst);
      end
   endtask

   task automatic test_saturation();
      next_cycle(); idle(); dmem_req = 1'b1;
      exp_q.push_back('{"sat_hold", O_MEM});
      for (int i = 1; i < 254; i++) begin
         next_cycle();
         exp_q.push_back('{"sat_hold", O_MEM});
      end
      next_cycle(); dmem_ready = 1'b1;
      exp_q.push_back('{"sat_release", O_NONE});
      next_cycle(); idle();
      checks++;
      if (stall_cycles !== 8'hFE) begin
         errors++; $display("FAIL sat_stall_pre got %0d want 254", stall_cycles);
      end
      dmem_req = 1'b1;
      exp_q.push_back('{"sat_hold_top", O_MEM});
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         exp_q.push_back('{"sat_hold_top", O_MEM});
      end
      next_cycle(); dmem_ready = 1'b1;
      exp_q.push_back('{"sat_release_top", O_NONE});
      next_cycle(); idle();
      checks++;
      if (stall_cycles !== 8'hFF) begin
         errors++; $display("FAIL sat_stall_top got %0d want 255", stall_cycles);
      end
      ex_redirect = 1'b1; ex_target = 32'h800;
      exp_q.push_back('{"sat_redir", O_REDIR});
      for (int i = 1; i < 254; i++) begin
         next_cycle();
         exp_q.push_back('{"sat_redir", O_REDIR});
      end
      next_cycle();
      checks++;
      if (flush_count !== 8'hFE) begin
         errors++; $display("FAIL sat_flush_pre got %0d want 254", flush_count);
      end
      exp_q.push_back('{"sat_redir_top", O_REDIR});
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         exp_q.push_back('{"sat_redir_top", O_REDIR});
      end
      next_cycle(); idle();
      exp_q.push_back('{"sat_done", O_NONE});
      checks++;
      if (flush_count !== 8'hFF || stall_cycles !== 8'hFF) begin
         errors++; $display("FAIL sat_final got %0d/%0d want 255/255", flush_count, stall_cycles);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_load_use();
      test_no_hazard();
      test_redirect();
      test_mem_wait();
      test_reset_mid();
      test_saturation();
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_hazard_sequencer
